spi_slave_fifo: RTL and testbench
=================================

SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 SHALL have parameter p_fifo_in_depth, default 256, RX FIFO depth in bytes, power of two >= 4.
REQ-002 SHALL have parameter p_fifo_out_depth, default 128, TX FIFO depth in bytes, power of two >= 4.
REQ-003 SHALL have parameter p_sync_stages, default 2, synchroniser flops on i_sck/i_csb/i_sdi, range 2..3.
REQ-004 i_clk  in  1  single global clock; all logic on its rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_addr  in  30 [31:2]  word address; block decodes i_addr[4:2].
REQ-007 i_be  in  4  write byte enables.
REQ-008 i_wr_en / i_rd_en  in  1 each  bus write/read strobes.
REQ-009 i_wr_data  in  32  write data; o_rd_data  out  32  read data.
REQ-010 o_busy  out  1  tied 0; o_ack  out  1  transfer acknowledge.
REQ-011 i_sck, i_csb, i_sdi  in  1 each  SPI clock, chip select (active-low), MOSI.
REQ-012 o_sdo, o_sdo_en  out  1 each  MISO, MISO output enable.

Function
REQ-013 Registers (i_addr[4:2]): 0 CONFIG, 1 STATUS, 2 DATA_TX, 3 DATA_RX, 4 START_PATTERN, 5 START_PATTERN_MSK; 6,7 unmapped.
REQ-014 CONFIG: [0] enable, [1] rx_flush, [2] tx_flush (both self-clear next cycle), [15:8] idle_byte; byte-enable writes.
REQ-015 STATUS read-only except W1C: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_ovf (W1C), [5] tx_ovf (W1C), [6] synced, [31:16] rx_level.
REQ-016 o_ack SHALL equal i_wr_en|i_rd_en on mapped addresses, same cycle; unmapped access gives o_ack=0, no side effect.
REQ-017 Read data SHALL be registered: o_rd_data valid the cycle after i_rd_en, held until next read.
REQ-018 Read of DATA_RX SHALL return {24'b0, head byte} and pop RX FIFO; when empty return 0, no pop.
REQ-019 Write of DATA_TX with i_be[0] SHALL push i_wr_data[7:0]; when full, drop byte and set tx_ovf.
REQ-020 SPI mode 0, MSB first: sample SDI on synchronised SCK rising edge, update SDO on falling edge.
REQ-021 SPI FSM states IDLE, HUNT, RECV; IDLE when CSb high or enable=0.
REQ-022 CSb falling: IDLE->HUNT (macro on) or IDLE->RECV (macro off); bit counter cleared; TX byte loaded.
REQ-023 In RECV each 8th sampled bit SHALL push the byte to RX FIFO one cycle later; when full, drop and set rx_ovf.
REQ-024 CSb rising mid-byte SHALL discard partial byte, return to IDLE, leave FIFOs intact.
REQ-025 TX byte load at CSb fall and after each 8th bit: pop TX FIFO head if non-empty and state RECV, else idle_byte.
REQ-026 o_sdo_en SHALL equal synchronised ~CSb & enable; o_sdo = TX shift MSB.
REQ-027 Simultaneous push and pop on a full or empty FIFO SHALL both succeed (level unchanged).
REQ-028 Flush SHALL zero the level and pointers; flush wins over a same-cycle push.
REQ-029 Pointers SHALL wrap modulo depth; level width clog2(depth)+1.
REQ-030 synced SHALL be 1 exactly while state is RECV.

Reset
REQ-031 On i_rst_n low: FSM IDLE, FIFOs empty, flags 0, o_rd_data 0, o_sdo 0, o_sdo_en 0, CONFIG 0x00000001, START_PATTERN 0x00FFA5A5, START_PATTERN_MSK 0x00FFFFFF.
REQ-032 Reset mid-frame SHALL lose the frame; after release, block waits for next CSb falling edge.

Configuration
REQ-033 Macro SPI_SLAVE_START_PATTERN_EN defined: HUNT shifts bytes into 32-bit window; at each byte boundary ((window^START_PATTERN)&MSK)==0 moves to RECV; pattern bytes not stored; TX outputs idle_byte in HUNT.
REQ-034 Macro undefined: HUNT, window and registers 4/5 absent (unmapped, o_ack=0); CSb fall goes straight to RECV.

Verification
REQ-035 Macro off: CSb low, MOSI 0x3C,0xC3 -> DATA_RX reads 0x3C then 0xC3, then 0x00 with rx_empty=1.
REQ-036 Macro on: MOSI FF A5 A5 11 -> RX FIFO holds only 0x11; synced=1 after 3rd byte.
REQ-037 DATA_TX writes 0xAB,0xCD, idle_byte 0x5A, 3-byte frame -> MISO 0xAB,0xCD,0x5A (macro off).
REQ-038 Push p_fifo_in_depth+1 bytes without reads -> rx_full=1, rx_ovf=1, level=depth; W1C bit 4 clears rx_ovf.
REQ-039 CSb high after 5 bits, then 0x77 frame -> only 0x77 stored.
REQ-040 i_rst_n low mid-byte -> all outputs at reset values within same cycle, FIFOs empty.

Source files
------------

// File: rtl/spi_slave_fifo_if.sv
// Register-bus bundle for spi_slave_fifo: word-addressed strobed reads/writes with a
// same-cycle acknowledge and registered read data.
interface spi_slave_fifo_if;
    logic [31:2] i_addr;
    logic [3:0]  i_be;
    logic        i_wr_en;
    logic        i_rd_en;
    logic [31:0] i_wr_data;
    logic [31:0] o_rd_data;
    logic        o_busy;
    logic        o_ack;

    modport master (
        output i_addr, i_be, i_wr_en, i_rd_en, i_wr_data,
        input  o_rd_data, o_busy, o_ack
    );

    modport slave (
        input  i_addr, i_be, i_wr_en, i_rd_en, i_wr_data,
        output o_rd_data, o_busy, o_ack
    );
endinterface

// File: rtl/spi_slave_fifo.sv
// SPI mode-0 slave with RX/TX byte FIFOs behind a small register bus.
// Define SPI_SLAVE_START_PATTERN_EN to hunt for a masked start pattern before storing bytes.
module spi_slave_fifo #(
    parameter int unsigned p_fifo_in_depth  = 256,
    parameter int unsigned p_fifo_out_depth = 128,
    parameter int unsigned p_sync_stages    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    spi_slave_fifo_if.slave bus,
    input  logic            i_sck,
    input  logic            i_csb,
    input  logic            i_sdi,
    output logic            o_sdo,
    output logic            o_sdo_en
);
    localparam int unsigned RxAw = $clog2(p_fifo_in_depth);
    localparam int unsigned TxAw = $clog2(p_fifo_out_depth);
    localparam logic [RxAw:0] RxFullLvl = (RxAw + 1)'(p_fifo_in_depth);
    localparam logic [TxAw:0] TxFullLvl = (TxAw + 1)'(p_fifo_out_depth);

    typedef enum logic [1:0] {StIdle, StHunt, StRecv} state_e;

    logic [p_sync_stages-1:0] sck_sync_q, csb_sync_q, sdi_sync_q;
    logic [p_sync_stages:0]   sync_fill_q;
    logic sck_prev_q, csb_prev_q, sck_s, csb_s, sdi_s;
    logic sck_rise, sck_fall, csb_fall;

    logic       cfg_en_q, cfg_rx_flush_q, cfg_tx_flush_q;
    logic [7:0] cfg_idle_q;
    logic       rx_ovf_q, tx_ovf_q;
    logic [31:0] rd_data_q, rdata, status;

    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_shift_q;
    logic [7:0] tx_shift_q, rx_push_byte_q;
    logic       rx_push_q;

    logic [7:0]      rx_mem [p_fifo_in_depth];
    logic [RxAw-1:0] rx_wptr_q, rx_rptr_q;
    logic [RxAw:0]   rx_level_q;
    logic [7:0]      tx_mem [p_fifo_out_depth];
    logic [TxAw-1:0] tx_wptr_q, tx_rptr_q;
    logic [TxAw:0]   tx_level_q;

    logic [2:0] reg_sel;
    logic mapped, wr, stat_w1c;
    logic rx_empty, rx_full, rx_avail, rx_pop, rx_push_ok;
    logic tx_empty, tx_full, tx_avail, tx_push, tx_pop, tx_push_ok;
    logic [7:0] rx_head, tx_head, rx_byte, load_byte;
    logic in_frame, start, byte_done, load_recv;
    logic unused_bits;

    // Input synchronisers; the fill chain stops a CSb held low through reset looking like a fall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync_q  <= '0;
            csb_sync_q  <= '1;
            sdi_sync_q  <= '0;
            sync_fill_q <= '0;
            sck_prev_q  <= 1'b0;
            csb_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[p_sync_stages-2:0], i_sck};
            csb_sync_q  <= {csb_sync_q[p_sync_stages-2:0], i_csb};
            sdi_sync_q  <= {sdi_sync_q[p_sync_stages-2:0], i_sdi};
            sync_fill_q <= {sync_fill_q[p_sync_stages-1:0], 1'b1};
            sck_prev_q  <= sck_s;
            csb_prev_q  <= csb_s;
        end
    end

    assign sck_s    = sck_sync_q[p_sync_stages-1];
    assign csb_s    = csb_sync_q[p_sync_stages-1];
    assign sdi_s    = sdi_sync_q[p_sync_stages-1];
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;
    assign csb_fall = csb_prev_q & ~csb_s & sync_fill_q[p_sync_stages];

    assign reg_sel = bus.i_addr[4:2];
`ifdef SPI_SLAVE_START_PATTERN_EN
    logic [31:0] pat_q, msk_q, window_q, window_d;
    logic hunt_match, unused_window;
    assign mapped        = reg_sel <= 3'd5;
    assign window_d      = {window_q[23:0], rx_byte};
    assign hunt_match    = ((window_d ^ pat_q) & msk_q) == '0;
    assign load_recv     = start ? 1'b0 : ((state_q == StRecv) | hunt_match);
    assign unused_window = ^window_q[31:24];
`else
    assign mapped    = reg_sel <= 3'd3;
    assign load_recv = 1'b1;
`endif
    assign bus.o_ack     = (bus.i_wr_en | bus.i_rd_en) & mapped;
    assign bus.o_busy    = 1'b0;
    assign bus.o_rd_data = rd_data_q;
    assign wr            = bus.i_wr_en & mapped;
    assign stat_w1c      = wr & (reg_sel == 3'd1) & bus.i_be[0];
    assign unused_bits   = ^{bus.i_addr[31:5], bus.i_wr_data[31:16], bus.i_be[3:2]};

    // Both FIFOs bypass the pushed byte when empty so a same-cycle push and pop both succeed.
    assign rx_empty   = rx_level_q == '0;
    assign rx_full    = rx_level_q == RxFullLvl;
    assign rx_avail   = ~rx_empty | rx_push_q;
    assign rx_head    = rx_empty ? rx_push_byte_q : rx_mem[rx_rptr_q];
    assign rx_pop     = bus.i_rd_en & (reg_sel == 3'd3) & rx_avail;
    assign rx_push_ok = rx_push_q & (~rx_full | rx_pop);

    assign tx_empty   = tx_level_q == '0;
    assign tx_full    = tx_level_q == TxFullLvl;
    assign tx_push    = wr & (reg_sel == 3'd2) & bus.i_be[0];
    assign tx_avail   = ~tx_empty | tx_push;
    assign tx_head    = tx_empty ? bus.i_wr_data[7:0] : tx_mem[tx_rptr_q];
    assign tx_push_ok = tx_push & (~tx_full | tx_pop);

    assign in_frame  = (state_q != StIdle) & ~csb_s & cfg_en_q;
    assign start     = (state_q == StIdle) & csb_fall & cfg_en_q;
    assign byte_done = in_frame & sck_rise & (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_shift_q, sdi_s};
    assign tx_pop    = (start | byte_done) & load_recv & tx_avail;
    assign load_byte = tx_pop ? tx_head : cfg_idle_q;
    assign o_sdo     = tx_shift_q[7];
    assign o_sdo_en  = ~csb_s & cfg_en_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            rx_push_q      <= 1'b0;
            rx_push_byte_q <= '0;
`ifdef SPI_SLAVE_START_PATTERN_EN
            window_q       <= '0;
`endif
        end else begin
            rx_push_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
`ifdef SPI_SLAVE_START_PATTERN_EN
                        state_q  <= StHunt;
                        window_q <= '0;
`else
                        state_q  <= StRecv;
`endif
                        bit_cnt_q  <= '0;
                        tx_shift_q <= load_byte;
                    end
                end
                default: begin
                    if (!in_frame) begin
                        state_q <= StIdle;
                    end else if (sck_rise) begin
                        rx_shift_q <= rx_byte[6:0];
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            tx_shift_q <= load_byte;
                            if (state_q == StRecv) begin
                                rx_push_q      <= 1'b1;
                                rx_push_byte_q <= rx_byte;
                            end
`ifdef SPI_SLAVE_START_PATTERN_EN
                            else begin
                                window_q <= window_d;
                                if (hunt_match) state_q <= StRecv;
                            end
`endif
                        end
                    end else if (sck_fall && bit_cnt_q != 3'd0) begin
                        // Skip the fall right after a reload so the new MSB is held.
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_en_q       <= 1'b1;
            cfg_rx_flush_q <= 1'b0;
            cfg_tx_flush_q <= 1'b0;
            cfg_idle_q     <= '0;
`ifdef SPI_SLAVE_START_PATTERN_EN
            pat_q          <= 32'h00FF_A5A5;
            msk_q          <= 32'h00FF_FFFF;
`endif
        end else begin
            cfg_rx_flush_q <= 1'b0;
            cfg_tx_flush_q <= 1'b0;
            if (wr && reg_sel == 3'd0) begin
                if (bus.i_be[0]) begin
                    cfg_en_q       <= bus.i_wr_data[0];
                    cfg_rx_flush_q <= bus.i_wr_data[1];
                    cfg_tx_flush_q <= bus.i_wr_data[2];
                end
                if (bus.i_be[1]) cfg_idle_q <= bus.i_wr_data[15:8];
            end
`ifdef SPI_SLAVE_START_PATTERN_EN
            for (int b = 0; b < 4; b++) begin
                if (wr && bus.i_be[b] && reg_sel == 3'd4) pat_q[b*8 +: 8] <= bus.i_wr_data[b*8 +: 8];
                if (wr && bus.i_be[b] && reg_sel == 3'd5) msk_q[b*8 +: 8] <= bus.i_wr_data[b*8 +: 8];
            end
`endif
        end
    end

    // Flush zeroes pointers and level and beats a same-cycle push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
            rx_ovf_q   <= 1'b0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
            tx_ovf_q   <= 1'b0;
        end else begin
            if (cfg_rx_flush_q) begin
                rx_wptr_q  <= '0;
                rx_rptr_q  <= '0;
                rx_level_q <= '0;
            end else begin
                if (rx_push_ok) rx_wptr_q <= rx_wptr_q + RxAw'(1);
                if (rx_pop) rx_rptr_q <= rx_rptr_q + RxAw'(1);
                if (rx_push_ok && !rx_pop) rx_level_q <= rx_level_q + (RxAw + 1)'(1);
                else if (!rx_push_ok && rx_pop) rx_level_q <= rx_level_q - (RxAw + 1)'(1);
            end
            if (cfg_tx_flush_q) begin
                tx_wptr_q  <= '0;
                tx_rptr_q  <= '0;
                tx_level_q <= '0;
            end else begin
                if (tx_push_ok) tx_wptr_q <= tx_wptr_q + TxAw'(1);
                if (tx_pop) tx_rptr_q <= tx_rptr_q + TxAw'(1);
                if (tx_push_ok && !tx_pop) tx_level_q <= tx_level_q + (TxAw + 1)'(1);
                else if (!tx_push_ok && tx_pop) tx_level_q <= tx_level_q - (TxAw + 1)'(1);
            end
            if (rx_push_q && !rx_push_ok && !cfg_rx_flush_q) rx_ovf_q <= 1'b1;
            else if (stat_w1c && bus.i_wr_data[4]) rx_ovf_q <= 1'b0;
            if (tx_push && !tx_push_ok && !cfg_tx_flush_q) tx_ovf_q <= 1'b1;
            else if (stat_w1c && bus.i_wr_data[5]) tx_ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (rx_push_ok && !cfg_rx_flush_q) rx_mem[rx_wptr_q] <= rx_push_byte_q;
        if (tx_push_ok && !cfg_tx_flush_q) tx_mem[tx_wptr_q] <= bus.i_wr_data[7:0];
    end

    always_comb begin
        status        = '0;
        status[0]     = rx_empty;
        status[1]     = rx_full;
        status[2]     = tx_empty;
        status[3]     = tx_full;
        status[4]     = rx_ovf_q;
        status[5]     = tx_ovf_q;
        status[6]     = state_q == StRecv;
        status[31:16] = 16'(rx_level_q);
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            3'd0: rdata = {16'b0, cfg_idle_q, 5'b0, cfg_tx_flush_q, cfg_rx_flush_q, cfg_en_q};
            3'd1: rdata = status;
            3'd3: rdata = {24'b0, rx_pop ? rx_head : 8'h00};
`ifdef SPI_SLAVE_START_PATTERN_EN
            3'd4: rdata = pat_q;
            3'd5: rdata = msk_q;
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rd_data_q <= '0;
        else if (bus.i_rd_en && mapped) rd_data_q <= rdata;
    end
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench for spi_slave_fifo (RX depth 8, TX depth 4); hand-computed expectations.
module tb_spi_slave_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sck = 1'b0, csb = 1'b1, sdi = 1'b0;
    logic sdo, sdo_en;
    int unsigned n_checks = 0, n_pass = 0;

    localparam logic [2:0] RegCfg = 3'd0, RegStat = 3'd1, RegTx = 3'd2, RegRx = 3'd3;
`ifdef SPI_SLAVE_START_PATTERN_EN
    localparam logic [31:0] CfgAfter = 32'h0000_0001;
`else
    localparam logic [31:0] CfgAfter = 32'h0000_5A01;
`endif

    always #5 clk = ~clk;

    spi_slave_fifo_if bus ();

    spi_slave_fifo #(
        .p_fifo_in_depth (8),
        .p_fifo_out_depth(4),
        .p_sync_stages   (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .i_sck   (sck),
        .i_csb   (csb),
        .i_sdi   (sdi),
        .o_sdo   (sdo),
        .o_sdo_en(sdo_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.i_addr    = {27'b0, a};
        bus.i_wr_data = d;
        bus.i_be      = be;
        bus.i_wr_en   = 1'b1;
        tick(1);
        bus.i_wr_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic ack);
        bus.i_addr  = {27'b0, a};
        bus.i_rd_en = 1'b1;
        #1 ack = bus.o_ack;
        tick(1);
        bus.i_rd_en = 1'b0;
        d = bus.o_rd_data;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic ack;
        bus_read(a, d, ack);
        check(tag, d, exp);
    endtask

    task automatic spi_byte(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            sdi = mosi[i];
            tick(6);
            miso[i] = sdo;
            sck = 1'b1;
            tick(6);
            sck = 1'b0;
        end
        tick(6);
    endtask

    task automatic cs_low();
        csb = 1'b0;
        tick(6);
    endtask

    task automatic cs_high();
        csb = 1'b1;
        tick(6);
    endtask

    task automatic preamble();
`ifdef SPI_SLAVE_START_PATTERN_EN
        logic [7:0] m;
        spi_byte(8'hFF, 8, m);
        spi_byte(8'hA5, 8, m);
        spi_byte(8'hA5, 8, m);
`endif
    endtask

    initial begin
        logic [31:0] d;
        logic ack;
        logic [7:0] m;
        bus.i_addr = '0;
        bus.i_be = '0;
        bus.i_wr_en = 1'b0;
        bus.i_rd_en = 1'b0;
        bus.i_wr_data = '0;
        #2 rst_n = 1'b0;
        tick(3);
        check("rst_rd_data", bus.o_rd_data, 32'h0);
        check("rst_sdo", {31'b0, sdo}, 32'h0);
        check("rst_sdo_en", {31'b0, sdo_en}, 32'h0);
        rst_n = 1'b1;
        tick(2);
        rd("cfg_reset", RegCfg, 32'h0000_0001);
        rd("status_reset", RegStat, 32'h0000_0005);
        bus_read(3'd6, d, ack);
        check("unmapped_ack", {31'b0, ack}, 32'h0);
        check("unmapped_hold", d, 32'h0000_0005);
`ifdef SPI_SLAVE_START_PATTERN_EN
        bus_read(3'd4, d, ack);
        check("pat_ack", {31'b0, ack}, 32'h1);
        check("pat_reset", d, 32'h00FF_A5A5);
        rd("msk_reset", 3'd5, 32'h00FF_FFFF);
        // Pattern bytes are swallowed; synced rises once the third pattern byte lands.
        cs_low();
        spi_byte(8'hFF, 8, m);
        spi_byte(8'hA5, 8, m);
        rd("hunt_not_synced", RegStat, 32'h0000_0005);
        spi_byte(8'hA5, 8, m);
        rd("synced_after_3", RegStat, 32'h0000_0045);
        spi_byte(8'h11, 8, m);
        cs_high();
        rd("hunt_rx0", RegRx, 32'h0000_0011);
        rd("hunt_rx_empty", RegRx, 32'h0000_0000);
`else
        bus_read(3'd4, d, ack);
        check("reg4_unmapped_ack", {31'b0, ack}, 32'h0);
        bus_write(RegTx, 32'h0000_00AB, 4'b0001);
        bus_write(RegTx, 32'h0000_00CD, 4'b0001);
        bus_write(RegCfg, 32'h0000_5A01, 4'b0011);
        cs_low();
        check("sdo_en_frame", {31'b0, sdo_en}, 32'h1);
        spi_byte(8'h3C, 8, m);
        check("miso0", {24'b0, m}, 32'h0000_00AB);
        spi_byte(8'hC3, 8, m);
        check("miso1", {24'b0, m}, 32'h0000_00CD);
        spi_byte(8'h99, 8, m);
        check("miso2_idle", {24'b0, m}, 32'h0000_005A);
        cs_high();
        check("sdo_en_idle", {31'b0, sdo_en}, 32'h0);
        rd("rx0", RegRx, 32'h0000_003C);
        rd("rx1", RegRx, 32'h0000_00C3);
        rd("rx2", RegRx, 32'h0000_0099);
        rd("rx_empty_read", RegRx, 32'h0000_0000);
        rd("status_empty", RegStat, 32'h0000_0005);
`endif
        // Partial byte then a clean frame: only the clean byte is stored.
        cs_low();
        preamble();
        spi_byte(8'hFF, 5, m);
        cs_high();
        cs_low();
        preamble();
        spi_byte(8'h77, 8, m);
        cs_high();
        rd("partial_then_77", RegRx, 32'h0000_0077);
        rd("partial_empty", RegStat, 32'h0000_0005);

        // RX overflow: 9 bytes into 8 entries.
        cs_low();
        preamble();
        for (int i = 1; i <= 9; i++) spi_byte(8'(i), 8, m);
        cs_high();
        rd("rx_full_ovf", RegStat, 32'h0008_0016);
        bus_write(RegStat, 32'h0000_0010, 4'b0001);
        rd("rx_ovf_w1c", RegStat, 32'h0008_0006);
        rd("rx_ovf_head", RegRx, 32'h0000_0001);
        rd("rx_level7", RegStat, 32'h0007_0004);
        bus_write(RegCfg, 32'h0000_0003, 4'b0001);
        tick(1);
        rd("rx_flush", RegStat, 32'h0000_0005);
        rd("cfg_flush_clr", RegCfg, CfgAfter);

        // TX overflow: 5 writes into 4 entries.
        for (int i = 0; i < 5; i++) bus_write(RegTx, 32'h0000_0010 + i, 4'b0001);
        rd("tx_full_ovf", RegStat, 32'h0000_0029);
        bus_write(RegCfg, 32'h0000_0005, 4'b0001);
        tick(1);
        rd("tx_flush", RegStat, 32'h0000_0025);
        bus_write(RegStat, 32'h0000_0020, 4'b0001);
        rd("tx_ovf_w1c", RegStat, 32'h0000_0005);

        // Reset in the middle of a byte.
        bus_write(RegTx, 32'h0000_00FF, 4'b0001);
        cs_low();
        preamble();
        spi_byte(8'hE0, 3, m);
`ifndef SPI_SLAVE_START_PATTERN_EN
        check("sdo_before_rst", {31'b0, sdo}, 32'h1);
`endif
        rd("cfg_before_rst", RegCfg, CfgAfter);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rd_data", bus.o_rd_data, 32'h0);
        check("midrst_sdo", {31'b0, sdo}, 32'h0);
        check("midrst_sdo_en", {31'b0, sdo_en}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        rd("midrst_status", RegStat, 32'h0000_0005);
        rd("midrst_cfg", RegCfg, 32'h0000_0001);
        // CSb still low from before the reset: no falling edge, so nothing is captured.
        spi_byte(8'h5A, 8, m);
        rd("no_frame_after_rst", RegStat, 32'h0000_0005);
        cs_high();
        cs_low();
        preamble();
        spi_byte(8'h42, 8, m);
        cs_high();
        rd("frame_after_rst", RegRx, 32'h0000_0042);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
